// File: rtl/fetch_line_buffer_pkg.sv
// Shared types for the single-line instruction fetch buffer.
package fetch_line_buffer_pkg;
  localparam int FLB_ADDR_W = 12;
  localparam int FLB_LINE_W = 128;
  localparam int FLB_CNT_W  = 16;

  typedef logic [FLB_ADDR_W-1:0] lc3b_line_addr;
  typedef logic [FLB_LINE_W-1:0] lc3b_line;

  typedef enum logic {FLB_IDLE, FLB_FETCH} lc3b_flb_state;
endpackage

// File: rtl/fetch_line_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_line_buffer.sv
// One-line zero-wait ifetch buffer in front of the icache, with data-side
// write snooping so stale code is never returned, plus hit/miss counters.
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int ADDR_W = FLB_ADDR_W,
  parameter int LINE_W = FLB_LINE_W,
  parameter int CNT_W  = FLB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_cyc,
  input  logic              up_stb,
  input  logic              up_we,
  input  logic [ADDR_W-1:0] up_adr,
  output logic [LINE_W-1:0] up_dat_s,
  output logic              up_ack,
  output logic              dn_cyc,
  output logic              dn_stb,
  output logic              dn_we,
  output logic [ADDR_W-1:0] dn_adr,
  input  logic [LINE_W-1:0] dn_dat_s,
  input  logic              dn_ack,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_adr,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  lc3b_flb_state     state;
  logic              valid;
  logic              poison;
  logic [ADDR_W-1:0] tag;
  logic [ADDR_W-1:0] fill_adr;
  logic [LINE_W-1:0] line;

  logic req, snoop_hit, hit, fetching, fill_poison, fill_ok, bypass, miss_start;
  logic unused_we;

  assign unused_we   = up_we;
  assign req         = up_cyc & up_stb;
  assign fetching    = (state == FLB_FETCH);
  assign snoop_hit   = snoop_we & valid & (snoop_adr == tag);
  assign hit         = req & valid & (up_adr == tag) & ~snoop_hit & ~fetching;
  assign miss_start  = ~fetching & req & ~hit & ~snoop_hit;
  // A write to the line in flight, even in the ack cycle, invalidates the fill.
  assign fill_poison = poison | (snoop_we & (snoop_adr == fill_adr));
  assign fill_ok     = fetching & dn_ack & ~fill_poison;
  assign bypass      = fill_ok & req & (up_adr == fill_adr);

  assign up_ack   = hit | bypass;
  assign up_dat_s = bypass ? dn_dat_s : line;
  assign dn_cyc   = fetching;
  assign dn_stb   = fetching;
  assign dn_we    = 1'b0;
  assign dn_adr   = fill_adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FLB_IDLE;
      valid    <= 1'b0;
      poison   <= 1'b0;
      tag      <= '0;
      fill_adr <= '0;
      line     <= '0;
    end else begin
      if (snoop_hit) valid <= 1'b0;
      case (state)
        FLB_IDLE: begin
          if (miss_start) begin
            fill_adr <= up_adr;
            poison   <= 1'b0;
            state    <= FLB_FETCH;
          end
        end
        FLB_FETCH: begin
          if (dn_ack) begin
            state  <= FLB_IDLE;
            poison <= 1'b0;
            if (!fill_poison) begin
              line  <= dn_dat_s;
              tag   <= fill_adr;
              valid <= 1'b1;
            end else begin
              valid <= 1'b0;
            end
          end else begin
            poison <= fill_poison;
          end
        end
        default: state <= FLB_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit (
    .clk(clk), .rst_n(rst_n), .inc(hit), .clr(cnt_clear), .count(hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk(clk), .rst_n(rst_n), .inc(fill_ok), .clr(cnt_clear), .count(miss_count)
  );
endmodule
